// File: rtl/tank_pkg.sv
// Shared types for the tank hit/score block: game states, bullet status codes,
// start key and winner encodings.
package tank_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StPlay   = 2'b01,
        StStruck = 2'b10,
        StOver   = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        HitNone   = 2'b00,
        HitFlight = 2'b01,
        HitWall   = 2'b10
    } hit_e;

    typedef enum logic [1:0] {
        WinNone  = 2'b00,
        WinTank0 = 2'b01,
        WinTank1 = 2'b10,
        WinDraw  = 2'b11
    } winner_e;

    localparam logic [7:0] KEY_START = 8'h2C;

    function automatic winner_e winner_of(input logic [1:0] l0, input logic [1:0] l1);
        if (l0 == 2'd0 && l1 == 2'd0) return WinDraw;
        if (l0 == 2'd0)               return WinTank1;
        if (l1 == 2'd0)               return WinTank0;
        return WinNone;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational overlap test of a bullet square against a tank square.
// Sums are widened to 11 bits so boxes near the 10-bit edge never wrap.
module box_overlap #(
    parameter int unsigned A_SIZE = 16,
    parameter int unsigned B_SIZE = 32
) (
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    output logic       overlap
);

    logic [10:0] ax, ay, bx, by;

    assign ax = {1'b0, a_x};
    assign ay = {1'b0, a_y};
    assign bx = {1'b0, b_x};
    assign by = {1'b0, b_y};

    assign overlap = (ax < bx + 11'(B_SIZE)) && (ax + 11'(A_SIZE) > bx) &&
                     (ay < by + 11'(B_SIZE)) && (ay + 11'(A_SIZE) > by);

endmodule

// File: rtl/tank_hit_score.sv
// Two-tank hit detection, lives, invulnerability and game-state sequencing.
// Optional sprite blink during invulnerability: define TANK_HIT_FLASH_EN.
module tank_hit_score import tank_pkg::*; #(
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned TANK_SIZE     = 32,
    parameter int unsigned BULLET_SIZE   = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] tank0_X,
    input  logic [9:0] tank0_Y,
    input  logic [9:0] tank1_X,
    input  logic [9:0] tank1_Y,
    input  logic [9:0] bullet0_X,
    input  logic [9:0] bullet0_Y,
    input  logic [9:0] bullet1_X,
    input  logic [9:0] bullet1_Y,
    input  logic [1:0] hit0,
    input  logic [1:0] hit1,
    output logic [1:0] game_state,
    output logic [1:0] lives0,
    output logic [1:0] lives1,
    output logic       bullet_kill0,
    output logic       bullet_kill1,
    output logic [1:0] winner,
    output logic       flash0,
    output logic       flash1
);

    localparam int unsigned  TimerW     = (INVULN_FRAMES < 16) ? 4 : $clog2(INVULN_FRAMES + 1);
    localparam logic [TimerW-1:0] InvulnLoad = TimerW'(INVULN_FRAMES);
    localparam logic [1:0]   LivesLoad  = 2'(LIVES_INIT);

    game_state_e       state_q, state_d;
    winner_e           winner_q, winner_d;
    logic [1:0]        lives0_q, lives0_d, lives1_q, lives1_d;
    logic [TimerW-1:0] timer0_q, timer0_d, timer1_q, timer1_d;
    logic              kill0_q, kill0_d, kill1_q, kill1_d;
    logic [2:0]        fsync_q;
    logic [1:0]        vld_q;
    logic              armed_q;
    logic              tick;
    logic              ov_b0_t1, ov_b1_t0;
    logic              strike0, strike1;

    // Arm only after a genuine low has been sampled, so a frame_clk already
    // high at reset release does not produce a spurious first tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsync_q <= 3'b000;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            fsync_q <= {fsync_q[1:0], frame_clk};
            vld_q   <= {vld_q[0], 1'b1};
            armed_q <= armed_q | (vld_q[1] & ~fsync_q[1]);
        end
    end

    assign tick = fsync_q[1] & ~fsync_q[2] & armed_q;

    box_overlap #(.A_SIZE(BULLET_SIZE), .B_SIZE(TANK_SIZE)) u_ov_b0_t1 (
        .a_x    (bullet0_X),
        .a_y    (bullet0_Y),
        .b_x    (tank1_X),
        .b_y    (tank1_Y),
        .overlap(ov_b0_t1)
    );

    box_overlap #(.A_SIZE(BULLET_SIZE), .B_SIZE(TANK_SIZE)) u_ov_b1_t0 (
        .a_x    (bullet1_X),
        .a_y    (bullet1_Y),
        .b_x    (tank0_X),
        .b_y    (tank0_Y),
        .overlap(ov_b1_t0)
    );

    assign strike0 = (hit1 == HitFlight) && ov_b1_t0 && (timer0_q == '0);
    assign strike1 = (hit0 == HitFlight) && ov_b0_t1 && (timer1_q == '0);

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        lives0_d = lives0_q;
        lives1_d = lives1_q;
        timer0_d = timer0_q;
        timer1_d = timer1_q;
        kill0_d  = 1'b0;
        kill1_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                lives0_d = LivesLoad;
                lives1_d = LivesLoad;
                timer0_d = '0;
                timer1_d = '0;
                winner_d = WinNone;
                if (tick && keycode == KEY_START) state_d = StPlay;
            end
            StPlay, StStruck: begin
                if (tick) begin
                    timer0_d = (timer0_q != '0) ? timer0_q - TimerW'(1) : '0;
                    timer1_d = (timer1_q != '0) ? timer1_q - TimerW'(1) : '0;
                    if (state_q == StStruck && (lives0_q == 2'd0 || lives1_q == 2'd0)) begin
                        state_d  = StOver;
                        winner_d = winner_of(lives0_q, lives1_q);
                    end else begin
                        if (strike0) begin
                            lives0_d = (lives0_q != 2'd0) ? lives0_q - 2'd1 : 2'd0;
                            timer0_d = InvulnLoad;
                            kill1_d  = 1'b1;
                        end
                        if (strike1) begin
                            lives1_d = (lives1_q != 2'd0) ? lives1_q - 2'd1 : 2'd0;
                            timer1_d = InvulnLoad;
                            kill0_d  = 1'b1;
                        end
                        if (strike0 || strike1) begin
                            state_d = StStruck;
                        end else if (timer0_d == '0 && timer1_d == '0) begin
                            state_d = StPlay;
                        end
                    end
                end
            end
            StOver: begin
                if (tick && keycode == KEY_START) begin
                    state_d  = StIdle;
                    lives0_d = LivesLoad;
                    lives1_d = LivesLoad;
                    timer0_d = '0;
                    timer1_d = '0;
                    winner_d = WinNone;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            winner_q <= WinNone;
            lives0_q <= LivesLoad;
            lives1_q <= LivesLoad;
            timer0_q <= '0;
            timer1_q <= '0;
            kill0_q  <= 1'b0;
            kill1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            lives0_q <= lives0_d;
            lives1_q <= lives1_d;
            timer0_q <= timer0_d;
            timer1_q <= timer1_d;
            kill0_q  <= kill0_d;
            kill1_q  <= kill1_d;
        end
    end

    assign game_state   = state_q;
    assign winner       = winner_q;
    assign lives0       = lives0_q;
    assign lives1       = lives1_q;
    assign bullet_kill0 = kill0_q;
    assign bullet_kill1 = kill1_q;

`ifdef TANK_HIT_FLASH_EN
    assign flash0 = timer0_q[3];
    assign flash1 = timer1_q[3];
`else
    assign flash0 = 1'b0;
    assign flash1 = 1'b0;
`endif

endmodule

// File: tb/tb_tank_hit_score.sv
// Directed bench for tank_hit_score: frame-level game model checked every
// settled cycle, plus hand-computed literal expectations at key points.
module tb_tank_hit_score;

    localparam int INV = 60;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] tank0_X, tank0_Y, tank1_X, tank1_Y;
    logic [9:0] bullet0_X, bullet0_Y, bullet1_X, bullet1_Y;
    logic [1:0] hit0, hit1;
    logic [1:0] game_state, lives0, lives1, winner;
    logic       bullet_kill0, bullet_kill1, flash0, flash1;

    int errors = 0;
    int checks = 0;
    bit settle = 1'b1;
    int kc0, kc1;

    // Frame-level model
    int m_state, m_l0, m_l1, m_t0, m_t1, m_win, exp_k0, exp_k1;

    tank_hit_score dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .tank0_X     (tank0_X),
        .tank0_Y     (tank0_Y),
        .tank1_X     (tank1_X),
        .tank1_Y     (tank1_Y),
        .bullet0_X   (bullet0_X),
        .bullet0_Y   (bullet0_Y),
        .bullet1_X   (bullet1_X),
        .bullet1_Y   (bullet1_Y),
        .hit0        (hit0),
        .hit1        (hit1),
        .game_state  (game_state),
        .lives0      (lives0),
        .lives1      (lives1),
        .bullet_kill0(bullet_kill0),
        .bullet_kill1(bullet_kill1),
        .winner      (winner),
        .flash0      (flash0),
        .flash1      (flash1)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit overlap(input int bx, input int by, input int tx, input int ty);
        return (bx < tx + 32) && (bx + 16 > tx) && (by < ty + 32) && (by + 16 > ty);
    endfunction

    function automatic int flash_of(input int t);
`ifdef TANK_HIT_FLASH_EN
        return (t / 8) % 2;
`else
        return 0 * t;
`endif
    endfunction

    task automatic model_reset();
        m_state = 0; m_l0 = 3; m_l1 = 3; m_t0 = 0; m_t1 = 0; m_win = 0;
    endtask

    task automatic model_step(input logic [7:0] key);
        bit s0, s1;
        exp_k0 = 0;
        exp_k1 = 0;
        case (m_state)
            0: if (key == 8'h2C) m_state = 1;
            1, 2: begin
                if (m_state == 2 && (m_l0 == 0 || m_l1 == 0)) begin
                    m_win   = (m_l0 == 0 && m_l1 == 0) ? 3 : (m_l0 == 0) ? 2 : 1;
                    m_state = 3;
                    m_t0    = (m_t0 > 0) ? m_t0 - 1 : 0;
                    m_t1    = (m_t1 > 0) ? m_t1 - 1 : 0;
                end else begin
                    s0 = (hit1 == 2'b01) && overlap(int'(bullet1_X), int'(bullet1_Y),
                                                    int'(tank0_X), int'(tank0_Y)) && m_t0 == 0;
                    s1 = (hit0 == 2'b01) && overlap(int'(bullet0_X), int'(bullet0_Y),
                                                    int'(tank1_X), int'(tank1_Y)) && m_t1 == 0;
                    m_t0 = s0 ? INV : ((m_t0 > 0) ? m_t0 - 1 : 0);
                    m_t1 = s1 ? INV : ((m_t1 > 0) ? m_t1 - 1 : 0);
                    if (s0) begin m_l0 = (m_l0 > 0) ? m_l0 - 1 : 0; exp_k1 = 1; end
                    if (s1) begin m_l1 = (m_l1 > 0) ? m_l1 - 1 : 0; exp_k0 = 1; end
                    if (s0 || s1) m_state = 2;
                    else if (m_t0 == 0 && m_t1 == 0) m_state = 1;
                end
            end
            default: if (key == 8'h2C) begin
                m_state = 0; m_l0 = 3; m_l1 = 3; m_t0 = 0; m_t1 = 0; m_win = 0;
            end
        endcase
    endtask

    // Compare process: settled outputs must match the model every cycle.
    always @(negedge Clk) begin
        if (settle) begin
            kc0 += int'(bullet_kill0);
            kc1 += int'(bullet_kill1);
        end else begin
            check("state", int'(game_state), m_state);
            check("lives0", int'(lives0), m_l0);
            check("lives1", int'(lives1), m_l1);
            check("winner", int'(winner), m_win);
            check("kill0_idle", int'(bullet_kill0), 0);
            check("kill1_idle", int'(bullet_kill1), 0);
            check("flash0", int'(flash0), flash_of(m_t0));
            check("flash1", int'(flash1), flash_of(m_t1));
        end
    end

    task automatic frame(input logic [7:0] key);
        @(posedge Clk); #1;
        keycode   = key;
        settle    = 1'b1;
        kc0       = 0;
        kc1       = 0;
        frame_clk = 1'b1;
        repeat (6) @(posedge Clk);
        #1;
        model_step(key);
        check("kill0_pulse", kc0, exp_k0);
        check("kill1_pulse", kc1, exp_k1);
        settle    = 1'b0;
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(8'h00);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; frame_clk = 1'b0; keycode = 8'h00;
        tank0_X = 10'd400; tank0_Y = 10'd400; tank1_X = 10'd90; tank1_Y = 10'd90;
        bullet0_X = 10'd100; bullet0_Y = 10'd100; bullet1_X = 10'd0; bullet1_Y = 10'd0;
        hit0 = 2'b00; hit1 = 2'b00;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check("rst_state", int'(game_state), 0);
        check("rst_lives0", int'(lives0), 3);
        check("rst_lives1", int'(lives1), 3);
        check("rst_winner", int'(winner), 0);
        check("rst_kill", int'(bullet_kill0 | bullet_kill1), 0);
        Reset_n = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        settle = 1'b0;

        // Start game
        frame(8'h00);
        check("idle_no_key", int'(game_state), 0);
        frame(8'h2C);
        check("start_state", int'(game_state), 1);
        check("start_lives", int'(lives0) * 4 + int'(lives1), 15);

        // bullet0 (100,100) on tank1 (90,90)
        hit0 = 2'b01;
        frame(8'h00);
        check("hit_lives1", int'(lives1), 2);
        check("hit_state", int'(game_state), 2);
        check("hit_kill0_cnt", kc0, 1);
        frames(59);
        check("inv59_lives1", int'(lives1), 2);
        check("inv59_state", int'(game_state), 2);
        frame(8'h00);
        check("inv60_state", int'(game_state), 1);

        // Edge cases on X: wall status, exclusive edges, one pixel inside
        hit0 = 2'b10; bullet0_X = 10'd200; bullet0_Y = 10'd200;
        tank1_X = 10'd216; tank1_Y = 10'd200;
        frame(8'h00);
        check("wall_lives1", int'(lives1), 2);
        hit0 = 2'b01;
        frame(8'h00);
        check("edge200_lives1", int'(lives1), 2);
        bullet0_X = 10'd184;
        frame(8'h00);
        check("edge184_lives1", int'(lives1), 2);
        bullet0_X = 10'd201;
        frame(8'h00);
        check("inside201_lives1", int'(lives1), 1);
        hit0 = 2'b00;
        frames(INV);
        check("back_play", int'(game_state), 1);

        // Near the 10-bit edge: tank0 at x=1000, bullet1 at x=1010
        tank0_X = 10'd1000; tank0_Y = 10'd500; bullet1_X = 10'd1010; bullet1_Y = 10'd510;
        hit1 = 2'b01;
        frame(8'h00);
        check("wrap_lives0", int'(lives0), 2);
        check("wrap_kill1_cnt", kc1, 1);
        hit1 = 2'b00;
        frames(INV);
        hit1 = 2'b01;
        frame(8'h00);
        check("second_lives0", int'(lives0), 1);
        hit1 = 2'b00;
        frames(INV);

        // Simultaneous hits at 1/1
        hit0 = 2'b01; hit1 = 2'b01;
        frame(8'h00);
        check("both_lives", int'(lives0) * 4 + int'(lives1), 0);
        check("both_kills", kc0 + kc1, 2);
        frame(8'h00);
        check("over_state", int'(game_state), 3);
        check("over_winner", int'(winner), 3);
        frame(8'h00);
        check("over_hold", int'(game_state), 3);
        frame(8'h2C);
        check("restart_idle", int'(game_state), 0);
        check("restart_lives", int'(lives0), 3);
        frame(8'h2C);
        frame(8'h00);
        check("replay_struck", int'(game_state), 2);

        // Asynchronous reset mid-STRUCK
        @(posedge Clk); #3;
        settle  = 1'b1;
        Reset_n = 1'b0;
        #1;
        check("midrst_state", int'(game_state), 0);
        check("midrst_lives1", int'(lives1), 3);
        check("midrst_kill", int'(bullet_kill0 | bullet_kill1), 0);
        model_reset();

        // Release reset with frame_clk high: the first rise must be ignored
        frame_clk = 1'b1; keycode = 8'h2C;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        check("rel_high_idle", int'(game_state), 0);
        frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        settle = 1'b0;
        frame(8'h2C);
        check("rel_then_play", int'(game_state), 1);

        repeat (4) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tank_hit_score.md
TANK_HIT_SCORE -- requirements
Module: tank_hit_score

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives each tank holds at game start (range 1..3).
REQ-002 Parameter INVULN_FRAMES, default 60: frames a tank ignores hits after being struck.
REQ-003 Parameter TANK_SIZE, default 32; parameter BULLET_SIZE, default 16: square sprite extents in pixels.
REQ-004 Clk  in  1  system clock, 50 MHz; single clock domain.
REQ-005 Reset_n  in  1  reset, asynchronous, active-low.
REQ-006 frame_clk  in  1  frame strobe, ~60 Hz, asynchronous to Clk.
REQ-007 keycode  in  8  current key; 8'h2C (Space) = start.
REQ-008 tank0_X, tank0_Y, tank1_X, tank1_Y  in  10 each  tank top-left corners.
REQ-009 bullet0_X, bullet0_Y, bullet1_X, bullet1_Y  in  10 each  bullet top-left corners.
REQ-010 hit0, hit1  in  2 each  bullet status: 00 none, 01 in flight, 10 hit wall.
REQ-011 game_state  out  2  00 IDLE, 01 PLAY, 10 STRUCK, 11 OVER.
REQ-012 lives0, lives1  out  2 each  remaining lives.
REQ-013 bullet_kill0, bullet_kill1  out  1 each  one-Clk pulse: retire that tank's bullet.
REQ-014 winner  out  2  00 none, 01 tank0, 10 tank1, 11 draw; valid in OVER.
REQ-015 flash0, flash1  out  1 each  sprite blank request during invulnerability.

Function
REQ-016 Detect frame_clk rising edge via two-flop synchronizer plus edge flop; all game updates occur only on the Clk cycle the edge flag is high ("frame tick").
REQ-017 Overlap test, unsigned 11-bit sums: bx < tx+TANK_SIZE && bx+BULLET_SIZE > tx, same on Y; no wrap at 10-bit edge.
REQ-018 Bullet0 tested against tank1 only, bullet1 against tank0 only; a test counts only when the owning hit input is 01.
REQ-019 IDLE: lives reload to LIVES_INIT, timers 0, winner 00; frame tick with keycode 8'h2C -> PLAY.
REQ-020 PLAY: on tick, a qualifying overlap on a non-invulnerable tank decrements its lives, loads its invuln timer with INVULN_FRAMES, pulses the shooter's bullet_kill on the same cycle -> STRUCK.
REQ-021 Simultaneous hits on the same tick: both tanks decrement, both kills pulse.
REQ-022 STRUCK: timers decrement by 1 per tick; lives0 or lives1 == 0 -> OVER next tick; both timers 0 -> PLAY; overlaps on an invulnerable tank ignored, no kill pulse.
REQ-023 A tank hit while the other is invulnerable still scores; STRUCK persists while either timer is non-zero.
REQ-024 OVER: winner = 11 if both lives 0, else survivor; holds until tick with keycode 8'h2C -> IDLE.
REQ-025 Lives saturate at 0; never underflow.
REQ-026 Output latency: lives, state, winner registered, update one Clk after the tick; bullet_kill asserted exactly one Clk.

Reset
REQ-027 Reset_n low: game_state 00, lives LIVES_INIT, winner 00, bullet_kill 0, flash 0, timers 0, synchronizer flops 0; asserts mid-game without waiting for a tick.
REQ-028 First tick after Reset_n release is honoured only if frame_clk was low at release.

Configuration
REQ-029 Macro TANK_HIT_FLASH_EN defined: flashN = bit 3 of tank N's invuln timer while timer non-zero (8-frame blink); undefined: flash0, flash1 tied 0, invulnerability unchanged.

Structure
REQ-030 Shared package tank_pkg: game-state enum, hit-status codes 00/01/10, KEY_START 8'h2C, winner encodings.
REQ-031 One sub-module box_overlap (combinational, two rectangles -> 1 bit), instantiated twice.

Verification
REQ-032 Reset, Space tick -> state 01, lives0 = lives1 = 3.
REQ-033 bullet0 (100,100), hit0 01, tank1 (90,90), tick -> lives1 = 2, bullet_kill0 one-Clk pulse, state 10.
REQ-034 Same overlap held 59 further ticks -> lives1 stays 2; 60th tick -> state 01.
REQ-035 Both bullets overlapping opposite tanks at lives 1/1, tick -> both lives 0, then OVER, winner 11.
REQ-036 bullet0 (200,200), tank1 (216,200), hit0 10 -> no decrement; bullet0 X = 184 -> no overlap (edge exclusive).
REQ-037 Reset_n low during STRUCK -> state 00 and lives 3 within one Clk, no pulses.
